// File: rtl/countdown_timer_mmss.sv
// MM:SS BCD countdown timer with pause, load, and a timed ring phase.
// Commands resolve by priority each cycle: stop, load, start, pause, tick.
module countdown_timer_mmss #(
  parameter int RING_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  output logic [15:0] mm_ss,
  output logic [1:0]  state,
  output logic        running,
  output logic        ring,
  output logic        expired_pulse
);

  localparam int CW = $clog2(RING_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_RING  = 2'b11
  } st_t;

  st_t            st_q, st_d;
  logic [15:0]    t_q, t_d;
  logic [CW-1:0]  rc_q, rc_d;
  logic           exp_d;
  logic           can_load;

  function automatic logic [3:0] sat(
    input logic [3:0] v,
    input logic [3:0] mx
  );
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] v);
    return {sat(v[15:12], 4'd5), sat(v[11:8], 4'd9),
            sat(v[7:4], 4'd5), sat(v[3:0], 4'd9)};
  endfunction

  function automatic logic [15:0] dec(input logic [15:0] v);
    logic [3:0] mt, mu, s10, s1;
    {mt, mu, s10, s1} = v;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, s10, s1};
  endfunction

  assign can_load = (st_q == S_IDLE) || (st_q == S_PAUSE);

  always_comb begin
    st_d  = st_q;
    t_d   = t_q;
    rc_d  = rc_q;
    exp_d = 1'b0;
    if (stop) begin
      if (st_q != S_IDLE) begin
        st_d = S_IDLE;
        rc_d = '0;
      end
    end else if (load) begin
      if (can_load) t_d = clamp(load_data);
    end else if (start) begin
      if (can_load && t_q != 16'h0000) st_d = S_RUN;
    end else if (pause) begin
      if (st_q == S_RUN) st_d = S_PAUSE;
    end else if (tick) begin
      unique case (st_q)
        S_RUN: begin
          if (t_q == 16'h0001) begin
            t_d   = 16'h0000;
            st_d  = S_RING;
            rc_d  = '0;
            exp_d = 1'b1;
          end else begin
            t_d = dec(t_q);
          end
        end
        S_RING: begin
          if (rc_q == CW'(RING_TICKS - 1)) begin
            st_d = S_IDLE;
            rc_d = '0;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= S_IDLE;
      t_q           <= 16'h0000;
      rc_q          <= '0;
      expired_pulse <= 1'b0;
    end else begin
      st_q          <= st_d;
      t_q           <= t_d;
      rc_q          <= rc_d;
      expired_pulse <= exp_d;
    end
  end

  assign mm_ss   = t_q;
  assign state   = st_q;
  assign running = (st_q == S_RUN);
  assign ring    = (st_q == S_RING);

endmodule
